// File: rtl/mvp_pkg.sv
// Shared types and sizes for the matrix-vector operand path.
package mvp_pkg;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int IDXW  = (N * N > 1) ? $clog2(N * N) : 1;
   localparam int VIDXW = (N > 1) ? $clog2(N) : 1;

   typedef logic [W-1:0]    half_t;
   typedef logic [IDXW-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_MAT,
      LOAD_VEC,
      PRESENT
   } ldr_state_t;

   localparam idx_t MAT_LAST = idx_t'(N * N - 1);
   localparam idx_t VEC_LAST = idx_t'(N - 1);

endpackage

// File: rtl/matrix_vector_loader.sv
// Serial-to-parallel operand loader: collects a row-major N x N matrix followed
// by an N-element vector from a valid/ready word stream, then holds both on
// registered outputs until the consumer takes them. Vector-only frames reuse
// the stored matrix.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for the first word of a frame (samples in_vec_only)
// LOAD_MAT | storing matrix words, idx = next row-major element
// LOAD_VEC | storing vector words, idx = next vector element
// PRESENT  | operands held, out_valid=1, input stalled until handshake
module matrix_vector_loader
   import mvp_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_data,
   input  logic               in_vec_only,
   output logic [N*N*W-1:0]   mat_flat,
   output logic [N*W-1:0]     vec_flat,
   output logic               mat_loaded,
   output logic               out_valid,
   input  logic               out_ready
);

   ldr_state_t        state_q, state_d;
   idx_t              idx_q, idx_d;
   logic              mat_loaded_q, mat_loaded_d;
   logic              out_valid_q, out_valid_d;
   logic              mat_we, vec_we;
   logic              accept;
   logic [VIDXW-1:0]  vec_idx;
   half_t             mat_q [N*N];
   half_t             vec_q [N];

   // in_ready is gated by rst_n so it reads 0 for the whole reset assertion
   assign in_ready   = rst_n && (state_q != PRESENT);
   assign accept     = in_valid && in_ready;
   assign vec_idx    = idx_q[VIDXW-1:0];
   assign mat_loaded = mat_loaded_q;
   assign out_valid  = out_valid_q;

   // Next-state, index and write-enable decode; flush overrides everything
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mat_loaded_d = mat_loaded_q;
      out_valid_d  = out_valid_q;
      mat_we       = 1'b0;
      vec_we       = 1'b0;
      if (flush) begin
         state_d     = IDLE;
         idx_d       = '0;
         out_valid_d = 1'b0;
         // a half-written matrix is no longer trustworthy
         if (state_q == LOAD_MAT) mat_loaded_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (!in_vec_only) begin
                     mat_we       = 1'b1;
                     idx_d        = idx_t'(1);
                     mat_loaded_d = 1'b0;
                     state_d      = LOAD_MAT;
                  end else begin
                     vec_we = 1'b1;
                     if (N == 1) begin
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = PRESENT;
                     end else begin
                        idx_d   = idx_t'(1);
                        state_d = LOAD_VEC;
                     end
                  end
               end
            end
            LOAD_MAT: begin
               if (accept) begin
                  mat_we = 1'b1;
                  if (idx_q == MAT_LAST) begin
                     idx_d        = '0;
                     mat_loaded_d = 1'b1;
                     state_d      = LOAD_VEC;
                  end else begin
                     idx_d = idx_q + idx_t'(1);
                  end
               end
            end
            LOAD_VEC: begin
               if (accept) begin
                  vec_we = 1'b1;
                  if (idx_q == VEC_LAST) begin
                     idx_d       = '0;
                     out_valid_d = 1'b1;
                     state_d     = PRESENT;
                  end else begin
                     idx_d = idx_q + idx_t'(1);
                  end
               end
            end
            PRESENT: begin
               if (out_valid_q && out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         mat_loaded_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mat_loaded_q <= mat_loaded_d;
         out_valid_q  <= out_valid_d;
      end
   end

   // Operand storage; written only on accepted words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N * N; i++) mat_q[i] <= '0;
         for (int i = 0; i < N; i++)     vec_q[i] <= '0;
      end else begin
         if (mat_we) mat_q[idx_q]   <= in_data;
         if (vec_we) vec_q[vec_idx] <= in_data;
      end
   end

   // Flatten storage onto the output buses (pure wiring from flops)
   always_comb begin
      mat_flat = '0;
      vec_flat = '0;
      for (int i = 0; i < N * N; i++) mat_flat[i*W +: W] = mat_q[i];
      for (int i = 0; i < N; i++)     vec_flat[i*W +: W] = vec_q[i];
   end

endmodule
